pkt_ring_buffer: RTL and testbench
==================================

Name: pkt_ring_buffer

Overview:
- Single-clock, multi-bank packet ring buffer. It generalises the two-bank ping-pong FIFO to NUM_BANKS banks of PKT_SIZE words each.
- Sits between the DAQ_sync byte stream and the SPI/WiFi readout.
- Writer fills banks round-robin. Reader may only drain complete packets.
- When all banks are occupied, whole incoming packets are dropped and counted, never partially overwritten.

Parameters:
- DATA_WIDTH, 8, width of din/dout.
- PKT_SIZE, 10, words per packet (one bank); production value 38912.
- NUM_BANKS, 4, number of packet banks; must be >= 2.
- BANK_AW, 13, offset counter width; must satisfy 2^BANK_AW >= PKT_SIZE.
- DROP_CW, 16, width of the dropped-packet counter.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  din valid this cycle.
- din  in  DATA_WIDTH  write data.
- sof  in  1  start-of-frame marker, qualified by wr_en (used only with the optional feature).
- rd_en  in  1  read request.
- valid  out  1  dout valid.
- dout  out  DATA_WIDTH  read data.
- rd_last  out  1  high together with valid on the last word of a packet.
- pkt_ready  out  1  at least one complete packet is stored.
- pkt_cnt  out  $clog2(NUM_BANKS+1)  number of complete packets stored.
- full  out  1  pkt_cnt == NUM_BANKS.
- overflow  out  1  one-cycle pulse when a packet drop begins.
- drop_cnt  out  DROP_CW  dropped packets, saturating.

Behaviour:
- Storage:
  - RAM of NUM_BANKS*PKT_SIZE words; address = bank*PKT_SIZE + offset.
  - Contents are not reset.
- Reset values: wr_bank=0, wr_off=0, rd_bank=0, rd_off=0, pkt_cnt=0, wstate=WRITE, valid=0, dout=0, rd_last=0, overflow=0, drop_cnt=0.
  - Reset asserted mid-operation discards all packets immediately.
- Writer FSM, states WRITE and DROP:
  - WRITE, wr_en with wr_off==0 and full=1: word discarded; go to DROP; drop counter word=1; overflow=1 for one cycle; drop_cnt++ (saturates at all-ones).
  - WRITE, otherwise on wr_en: write din at (wr_bank, wr_off).
    - If wr_off==PKT_SIZE-1: wr_off=0, wr_bank=(wr_bank+1) mod NUM_BANKS, and the bank is committed (pkt_cnt increments).
    - Else wr_off++.
  - DROP: each wr_en word is discarded. After PKT_SIZE words total, return to WRITE with wr_off=0.
    - Space freeing during DROP does not abort the drop.
  - Full can only be detected at wr_off==0, because a bank is free when its packet begins. A partially written bank is never read.
- Reader:
  - A read fires when rd_en=1 and pkt_cnt>0. rd_en with pkt_cnt==0 is ignored (valid=0 next cycle).
  - A fire registers RAM(rd_bank, rd_off) to dout with valid=1 on the next cycle (latency 1).
  - With rd_en held high, one word is delivered per cycle.
  - On a fire with rd_off==PKT_SIZE-1: rd_last=1 on that output word, rd_off=0, rd_bank advances mod NUM_BANKS, and the bank is released (pkt_cnt decrements).
  - dout holds its last value when valid=0.
- Simultaneous commit and release in one cycle: pkt_cnt unchanged.
- Commit while full: impossible by construction.
- pkt_ready and full are combinational from pkt_cnt.
- Wrap-around: bank indices wrap NUM_BANKS-1 -> 0. Write then read of the same bank address in the same cycle cannot occur, because reader and writer banks differ unless pkt_cnt is 0 or NUM_BANKS.

Optional Feature:
- Macro: PKT_SOF_SYNC_EN.
- Defined: wr_en & sof in WRITE with wr_off!=0 abandons the partial packet. The word is written at offset 0 of the same wr_bank and wr_off becomes 1. No commit occurs and drop_cnt increments.
  - sof in DROP, or with wr_off==0, has no special effect.
- Not defined: sof is ignored and packet boundaries are purely count-based.

Test Plan:
- Fill/drain: reset, write 10 bytes 0x00..0x09, then rd_en held high -> pkt_cnt 1 after the 10th write; dout 0x00..0x09 on consecutive cycles, valid latency 1, rd_last with 0x09; pkt_cnt back to 0.
- Wrap: 6 packets written with interleaved complete reads (read each packet after it is written) -> banks cycle 0,1,2,3,0,1; data intact; full never set.
- Overflow: write 50 bytes with no reads -> full after byte 40; overflow pulse on byte 41; drop_cnt=1; bytes 41..50 lost. Then read 40 -> only bytes 1..40 returned.
- Simultaneous: pkt_cnt=2, the final write of packet 3 and the final read of packet 1 fire in the same cycle -> pkt_cnt stays 2.
- Empty read / reset: rd_en with pkt_cnt=0 -> valid stays 0. Reset asserted mid-packet with 5 words written -> all outputs at reset values; the next 10 writes form bank 0.
- PKT_SOF_SYNC_EN: 4 bytes written, then sof with 0xAA followed by 9 bytes -> packet read starts 0xAA; drop_cnt=1.

Source files
------------

// File: rtl/pkt_ring_buffer.sv
// Multi-bank packet ring buffer: round-robin writer, whole-packet reader, drop-on-full with saturating count.
// Optional macro PKT_SOF_SYNC_EN: sof on a mid-packet word restarts the current bank at offset 0.
module pkt_ring_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_SIZE   = 10,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_AW    = 13,
  parameter int DROP_CW    = 16
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             sof,
  input  logic                             rd_en,
  output logic                             valid,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             rd_last,
  output logic                             pkt_ready,
  output logic [$clog2(NUM_BANKS+1)-1:0]   pkt_cnt,
  output logic                             full,
  output logic                             overflow,
  output logic [DROP_CW-1:0]               drop_cnt
);

  localparam int BW    = $clog2(NUM_BANKS);
  localparam int CW    = $clog2(NUM_BANKS + 1);
  localparam int DEPTH = NUM_BANKS * PKT_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [BANK_AW-1:0] LAST_OFF  = BANK_AW'(PKT_SIZE - 1);
  localparam logic [BW-1:0]      LAST_BANK = BW'(NUM_BANKS - 1);

  typedef enum logic {S_WRITE = 1'b0, S_DROP = 1'b1} wstate_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  wstate_t              r_wstate, w_wstate_nxt;
  logic [BW-1:0]        r_wr_bank, w_wr_bank_nxt;
  logic [BANK_AW-1:0]   r_wr_off, w_wr_off_nxt;
  logic [BANK_AW-1:0]   r_drop_word, w_drop_word_nxt;
  logic [BANK_AW-1:0]   w_we_off;
  logic                 w_we, w_commit, w_drop_start, w_drop_inc;

  logic [BW-1:0]        r_rd_bank;
  logic [BANK_AW-1:0]   r_rd_off;
  logic [CW-1:0]        r_pkt_cnt;
  logic                 r_valid, r_rd_last, r_overflow;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DROP_CW-1:0]   r_drop_cnt;

  logic                 w_rd_fire, w_rd_end, w_release;
  logic [AW-1:0]        w_wr_addr, w_rd_addr;

`ifndef PKT_SOF_SYNC_EN
  logic w_unused_sof;
  assign w_unused_sof = sof;
`endif

  assign full      = (r_pkt_cnt == CW'(NUM_BANKS));
  assign pkt_ready = (r_pkt_cnt != '0);
  assign pkt_cnt   = r_pkt_cnt;
  assign valid     = r_valid;
  assign dout      = r_dout;
  assign rd_last   = r_rd_last;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

  // Full is only judged at a packet boundary, so a packet is either stored whole or dropped whole.
  always_comb begin
    w_wstate_nxt    = r_wstate;
    w_wr_bank_nxt   = r_wr_bank;
    w_wr_off_nxt    = r_wr_off;
    w_drop_word_nxt = r_drop_word;
    w_we_off        = r_wr_off;
    w_we            = 1'b0;
    w_commit        = 1'b0;
    w_drop_start    = 1'b0;
    w_drop_inc      = 1'b0;
    case (r_wstate)
      S_WRITE: begin
        if (wr_en) begin
          if (r_wr_off == '0 && full) begin
            w_wstate_nxt    = S_DROP;
            w_drop_word_nxt = BANK_AW'(1);
            w_drop_start    = 1'b1;
            w_drop_inc      = 1'b1;
          end
`ifdef PKT_SOF_SYNC_EN
          else if (sof && r_wr_off != '0) begin
            w_we         = 1'b1;
            w_we_off     = '0;
            w_wr_off_nxt = BANK_AW'(1);
            w_drop_inc   = 1'b1;
          end
`endif
          else begin
            w_we = 1'b1;
            if (r_wr_off == LAST_OFF) begin
              w_wr_off_nxt  = '0;
              w_wr_bank_nxt = (r_wr_bank == LAST_BANK) ? '0 : r_wr_bank + BW'(1);
              w_commit      = 1'b1;
            end else begin
              w_wr_off_nxt = r_wr_off + BANK_AW'(1);
            end
          end
        end
      end
      S_DROP: begin
        if (wr_en) begin
          if (r_drop_word == LAST_OFF) begin
            w_wstate_nxt    = S_WRITE;
            w_drop_word_nxt = '0;
            w_wr_off_nxt    = '0;
          end else begin
            w_drop_word_nxt = r_drop_word + BANK_AW'(1);
          end
        end
      end
      default: w_wstate_nxt = S_WRITE;
    endcase
  end

  assign w_wr_addr = AW'(int'(r_wr_bank) * PKT_SIZE + int'(w_we_off));
  assign w_rd_addr = AW'(int'(r_rd_bank) * PKT_SIZE + int'(r_rd_off));
  assign w_rd_fire = rd_en && (r_pkt_cnt != '0);
  assign w_rd_end  = (r_rd_off == LAST_OFF);
  assign w_release = w_rd_fire && w_rd_end;

  always_ff @(posedge sys_clk) begin
    if (w_we) r_mem[w_wr_addr] <= din;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wstate    <= S_WRITE;
      r_wr_bank   <= '0;
      r_wr_off    <= '0;
      r_drop_word <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_wstate    <= w_wstate_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_wr_off    <= w_wr_off_nxt;
      r_drop_word <= w_drop_word_nxt;
      r_overflow  <= w_drop_start;
      if (w_drop_inc && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_bank <= '0;
      r_rd_off  <= '0;
      r_pkt_cnt <= '0;
      r_valid   <= 1'b0;
      r_dout    <= '0;
      r_rd_last <= 1'b0;
    end else begin
      r_valid   <= w_rd_fire;
      r_rd_last <= w_release;
      if (w_rd_fire) begin
        r_dout <= r_mem[w_rd_addr];
        if (w_rd_end) begin
          r_rd_off  <= '0;
          r_rd_bank <= (r_rd_bank == LAST_BANK) ? '0 : r_rd_bank + BW'(1);
        end else begin
          r_rd_off <= r_rd_off + BANK_AW'(1);
        end
      end
      if (w_commit && !w_release)      r_pkt_cnt <= r_pkt_cnt + CW'(1);
      else if (!w_commit && w_release) r_pkt_cnt <= r_pkt_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_pkt_ring_buffer.sv
// Directed bench for pkt_ring_buffer (default parameters: 10-word packets, 4 banks).
module tb_pkt_ring_buffer;
  localparam int PS = 10;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       wr_en     = 1'b0;
  logic [7:0] din       = 8'h00;
  logic       sof       = 1'b0;
  logic       rd_en     = 1'b0;
  logic       valid, rd_last, pkt_ready, full, overflow;
  logic [7:0] dout;
  logic [2:0] pkt_cnt;
  logic [15:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  pkt_ring_buffer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .din(din), .sof(sof),
    .rd_en(rd_en), .valid(valid), .dout(dout), .rd_last(rd_last), .pkt_ready(pkt_ready),
    .pkt_cnt(pkt_cnt), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] d, input logic s);
    wr_en = 1'b1;
    din   = d;
    sof   = s;
    tick();
    wr_en = 1'b0;
    sof   = 1'b0;
  endtask

  task automatic write_pkt(input logic [7:0] base);
    for (int i = 0; i < PS; i++) write_word(base + 8'(i), 1'b0);
  endtask

  task automatic read_pkt(input logic [7:0] base, input string tag);
    rd_en = 1'b1;
    for (int i = 0; i < PS; i++) begin
      tick();
      check({tag, "_vld"}, 32'(valid), 32'd1);
      check({tag, "_dat"}, 32'(dout), 32'(base + 8'(i)));
      check({tag, "_last"}, 32'(rd_last), (i == PS - 1) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;
  endtask

  logic [7:0] exp_sof [PS];

  initial begin
    // reset values
    repeat (3) tick();
    check("rst_vld", 32'(valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_last", 32'(rd_last), 32'd0);
    check("rst_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_rdy", 32'(pkt_ready), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // fill / drain
    for (int i = 0; i < PS - 1; i++) write_word(8'(i), 1'b0);
    check("fill_cnt9", 32'(pkt_cnt), 32'd0);
    write_word(8'h09, 1'b0);
    check("fill_cnt10", 32'(pkt_cnt), 32'd1);
    check("fill_rdy", 32'(pkt_ready), 32'd1);
    read_pkt(8'h00, "drain");
    check("drain_cnt", 32'(pkt_cnt), 32'd0);

    // empty read
    rd_en = 1'b1;
    tick();
    check("empty_vld", 32'(valid), 32'd0);
    check("empty_hold", 32'(dout), 32'h09);
    tick();
    check("empty_vld2", 32'(valid), 32'd0);
    rd_en = 1'b0;

    // wrap through every bank
    for (int p = 0; p < 6; p++) begin
      write_pkt(8'(8'h10 * (p + 1)));
      check("wrap_cnt", 32'(pkt_cnt), 32'd1);
      check("wrap_full", 32'(full), 32'd0);
      read_pkt(8'(8'h10 * (p + 1)), "wrap");
    end

    // overflow: bytes 1..50, no reads
    for (int k = 1; k <= 50; k++) begin
      write_word(8'(k), 1'b0);
      if (k == 39) check("ovf_full39", 32'(full), 32'd0);
      if (k == 40) begin
        check("ovf_full40", 32'(full), 32'd1);
        check("ovf_cnt40", 32'(pkt_cnt), 32'd4);
        check("ovf_pulse40", 32'(overflow), 32'd0);
      end
      if (k == 41) begin
        check("ovf_pulse41", 32'(overflow), 32'd1);
        check("ovf_drop41", 32'(drop_cnt), 32'd1);
      end
      if (k == 42) check("ovf_pulse42", 32'(overflow), 32'd0);
    end
    check("ovf_drop50", 32'(drop_cnt), 32'd1);
    check("ovf_cnt50", 32'(pkt_cnt), 32'd4);
    for (int p = 0; p < 4; p++) read_pkt(8'(1 + 10 * p), "ovf_rd");
    check("ovf_cnt_end", 32'(pkt_cnt), 32'd0);

    // simultaneous commit and release
    write_pkt(8'h60);
    write_pkt(8'h70);
    for (int i = 0; i < PS - 1; i++) write_word(8'h80 + 8'(i), 1'b0);
    check("sim_cnt_pre", 32'(pkt_cnt), 32'd2);
    rd_en = 1'b1;
    for (int i = 0; i < PS - 1; i++) begin
      tick();
      check("sim_dat", 32'(dout), 32'(8'h60 + 8'(i)));
    end
    wr_en = 1'b1;
    din   = 8'h89;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("sim_cnt", 32'(pkt_cnt), 32'd2);
    check("sim_last_dat", 32'(dout), 32'h69);
    check("sim_last", 32'(rd_last), 32'd1);
    read_pkt(8'h70, "sim_b");
    read_pkt(8'h80, "sim_c");
    check("sim_cnt_end", 32'(pkt_cnt), 32'd0);

    // reset mid-packet
    write_pkt(8'h40);
    for (int i = 0; i < 5; i++) write_word(8'h50 + 8'(i), 1'b0);
    check("mid_cnt_pre", 32'(pkt_cnt), 32'd1);
    sys_rst_n = 1'b0;
    #2;
    check("mid_cnt", 32'(pkt_cnt), 32'd0);
    check("mid_rdy", 32'(pkt_ready), 32'd0);
    check("mid_drop", 32'(drop_cnt), 32'd0);
    check("mid_dout", 32'(dout), 32'd0);
    check("mid_vld", 32'(valid), 32'd0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    write_pkt(8'h90);
    check("mid_cnt_post", 32'(pkt_cnt), 32'd1);
    read_pkt(8'h90, "mid_rd");

    // sof mid-packet
    for (int i = 0; i < 4; i++) write_word(8'h10 + 8'(i), 1'b0);
    write_word(8'hAA, 1'b1);
`ifdef PKT_SOF_SYNC_EN
    for (int i = 0; i < 9; i++) write_word(8'hB1 + 8'(i), 1'b0);
    exp_sof[0] = 8'hAA;
    for (int i = 1; i < PS; i++) exp_sof[i] = 8'hB0 + 8'(i);
    check("sof_drop", 32'(drop_cnt), 32'd1);
`else
    for (int i = 0; i < 5; i++) write_word(8'hB1 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) exp_sof[i] = 8'h10 + 8'(i);
    exp_sof[4] = 8'hAA;
    for (int i = 5; i < PS; i++) exp_sof[i] = 8'hB1 + 8'(i - 5);
    check("sof_drop", 32'(drop_cnt), 32'd0);
`endif
    check("sof_cnt", 32'(pkt_cnt), 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < PS; i++) begin
      tick();
      check("sof_dat", 32'(dout), 32'(exp_sof[i]));
    end
    rd_en = 1'b0;
    check("sof_cnt_end", 32'(pkt_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
